// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit driving the DataPath strobes.
// Each instruction runs fetch (F0-F2), operand read (E3), ALU launch (E4),
// ALU wait (WT) and writeback (W5, or W5L/W6H for MUL/DIV). HALT parks the
// unit until clear.
//
// Optional feature macro: CTRL_WAIT_TIMEOUT_EN
//   When defined, the WT state is bounded to WAIT_LIMIT cycles. On expiry the
//   unit enters HALT and raises fault, which holds until clear.
//
// Ports:
//   Clock              system clock, rising edge
//   clear              synchronous active-low reset
//   IR[31:0]           instruction register from DataPath
//   finished           ALU completion strobe (sampled only in WT)
//   RFout..RLOout      bus source selects
//   RFin..RLOin        register write enables
//   RFSelect[3:0]      register-file index
//   opSelect[5:0]      ALU operation {1'b0, opcode}
//   start              ALU start pulse (E4 only)
//   Read, MDRin, MDRout, IncPC  memory / PC strobes
//   run                high while sequencing (low in RST and HALT)
//   fault              ALU timeout flag
module control_sequencer #(
  parameter int WAIT_LIMIT = 64
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        finished,
  output logic        RFout,
  output logic        PCout,
  output logic        IRout,
  output logic        RYout,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        MARout,
  output logic        RHIout,
  output logic        RLOout,
  output logic        RFin,
  output logic        PCin,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        MARin,
  output logic        RHIin,
  output logic        RLOin,
  output logic [3:0]  RFSelect,
  output logic [5:0]  opSelect,
  output logic        start,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IncPC,
  output logic        run,
  output logic        fault
);

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_F0   = 4'd1,
    ST_F1   = 4'd2,
    ST_F2   = 4'd3,
    ST_E3   = 4'd4,
    ST_E4   = 4'd5,
    ST_WT   = 4'd6,
    ST_W5   = 4'd7,
    ST_W5L  = 4'd8,
    ST_W6H  = 4'd9,
    ST_HALT = 4'd10
  } state_t;

  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t     state_r;
  state_t     state_s;
  logic [4:0] opcode_r;
  logic [3:0] ra_r;
  logic [3:0] rc_r;
  logic       timeout_s;

  // Rb is only needed during E3 itself, so it is taken straight from IR and
  // never latched; the low IR bits carry no information for this unit.
  logic       unused_ir_s;
  assign unused_ir_s = ^IR[14:0];

`ifdef CTRL_WAIT_TIMEOUT_EN
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             fault_r;

  // Watchdog fires on the last allowed WT cycle if the ALU is still busy.
  assign timeout_s = (state_r == ST_WT) && !finished && (wait_cnt_r == CNT_LAST);
  assign fault     = fault_r;

  // Wait counter (cleared entering WT) and sticky fault flag.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      wait_cnt_r <= '0;
      fault_r    <= 1'b0;
    end else begin
      if (state_r == ST_E4) begin
        wait_cnt_r <= '0;
      end else if (state_r == ST_WT) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      fault_r <= fault_r | timeout_s;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign fault     = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_r <= ST_RST;
    end else begin
      state_r <= state_s;
    end
  end

  // Instruction fields, captured once in E3 and held through writeback.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      opcode_r <= 5'd0;
      ra_r     <= 4'd0;
      rc_r     <= 4'd0;
    end else if (state_r == ST_E3) begin
      opcode_r <= IR[31:27];
      ra_r     <= IR[26:23];
      rc_r     <= IR[18:15];
    end else begin
      opcode_r <= opcode_r;
      ra_r     <= ra_r;
      rc_r     <= rc_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RST:  state_s = ST_F0;
      ST_F0:   state_s = ST_F1;
      ST_F1:   state_s = ST_F2;
      ST_F2:   state_s = ST_E3;
      ST_E3:   state_s = (IR[31:27] == OP_HALT) ? ST_HALT : ST_E4;
      ST_E4:   state_s = ST_WT;
      ST_WT: begin
        if (finished) begin
          state_s = ((opcode_r == OP_MUL) || (opcode_r == OP_DIV)) ? ST_W5L : ST_W5;
        end else if (timeout_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_WT;
        end
      end
      ST_W5:   state_s = ST_F0;
      ST_W5L:  state_s = ST_W6H;
      ST_W6H:  state_s = ST_F0;
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_RST;
    endcase
  end

  // Moore output decode; everything not named for a state stays 0.
  always_comb begin
    RFout = 1'b0; PCout = 1'b0; IRout = 1'b0; RYout = 1'b0;
    RZLOout = 1'b0; RZHIout = 1'b0; MARout = 1'b0; RHIout = 1'b0; RLOout = 1'b0;
    RFin = 1'b0; PCin = 1'b0; IRin = 1'b0; RYin = 1'b0; RZin = 1'b0;
    MARin = 1'b0; RHIin = 1'b0; RLOin = 1'b0;
    RFSelect = 4'd0; opSelect = 6'd0; start = 1'b0;
    Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IncPC = 1'b0;
    run = (state_r != ST_RST) && (state_r != ST_HALT);
    case (state_r)
      ST_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
      ST_F1: begin RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_F2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_E3: begin
        // A HALT instruction asserts nothing on its way out.
        if (IR[31:27] != OP_HALT) begin
          RFSelect = IR[22:19]; RFout = 1'b1; RYin = 1'b1;
        end else begin
          RFSelect = 4'd0;
        end
      end
      ST_E4: begin
        RFSelect = rc_r; RFout = 1'b1; RZin = 1'b1;
        opSelect = {1'b0, opcode_r}; start = 1'b1;
      end
      ST_WT:   opSelect = {1'b0, opcode_r};
      ST_W5:   begin RFSelect = ra_r; RZLOout = 1'b1; RFin = 1'b1; end
      ST_W5L:  begin RZLOout = 1'b1; RLOin = 1'b1; end
      ST_W6H:  begin RZHIout = 1'b1; RHIin = 1'b1; end
      default: run = run;
    endcase
  end

endmodule
